// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port text-mode video RAM (4 KB of char/attr
// bytes) between scanout and the CPU bus. Scanout always wins the port. CPU
// reads and writes use the memory cycles that scanout leaves free.
//
// Build option: define VRAM_WRBUF_EN to add a WBUF_DEPTH-entry posted-write
// FIFO. With it, CPU writes are acknowledged as soon as they are queued and
// reads wait until the queue has drained. Without it, writes go straight to
// the RAM under arbitration and are acknowledged after they commit.
//
// Ports
//   clock, reset_n        system clock, synchronous active-low reset
//   vid_req, vid_a        scanout fetch request and byte address
//   vid_q                 scanout data (mem_q pass-through), valid the cycle
//                         after vid_req
//   cpu_req, cpu_we,
//   cpu_a, cpu_d          CPU request, held stable until cpu_ack
//   cpu_q, cpu_ack        CPU read data (held) and one-cycle completion pulse
//   mem_a, mem_d, mem_we  registered RAM address / write data / write enable
//   mem_q                 RAM read data for the address currently on mem_a
//   wbuf_busy             write buffer non-empty or a write still in flight
//
// FSM states
//   state      | meaning
//   ST_IDLE    | no CPU access issued to the RAM
//   ST_RD_WAIT | CPU read on mem_a this cycle, capture mem_q
//   ST_WR_WAIT | unbuffered CPU write on the port this cycle, ack next

module vram_arbiter #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        vid_req,
  input  logic [11:0] vid_a,
  output logic [7:0]  vid_q,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  output logic        cpu_ack,
  output logic [11:0] mem_a,
  output logic [7:0]  mem_d,
  output logic        mem_we,
  input  logic [7:0]  mem_q,
  output logic        wbuf_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_t;

  state_t state, state_next;

  logic        cpu_live;
  logic        grant_rd;
  logic        grant_wr;
  logic        push;
  logic        commit;
  logic [11:0] commit_a;
  logic [7:0]  commit_d;
  logic [11:0] mem_a_next;
  logic [7:0]  mem_d_next;
  logic        busy_next;

  // Scanout data is the RAM output itself; no extra latency on the video path.
  assign vid_q = mem_q;

  // The cycle carrying cpu_ack is ignored so a held request is not re-served.
  assign cpu_live = cpu_req && !cpu_ack && (state == ST_IDLE);

`ifdef VRAM_WRBUF_EN
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam logic [PTR_W:0] FULL_LV = (PTR_W + 1)'(WBUF_DEPTH);

  logic [11:0]      fifo_a [WBUF_DEPTH];
  logic [7:0]       fifo_d [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   level, level_next;
  logic             pop;

  // A read may only go out once the queue is empty and the last drained
  // write has left the port, so it always observes earlier writes.
  always_comb begin
    push     = cpu_live && cpu_we && (level != FULL_LV);
    grant_rd = 1'b0;
    pop      = 1'b0;
    if (!vid_req) begin
      if (cpu_live && !cpu_we && (level == '0) && !mem_we) begin
        grant_rd = 1'b1;
      end else if (level != '0) begin
        pop = 1'b1;
      end
    end
  end

  assign grant_wr   = 1'b0;
  assign commit     = pop;
  assign commit_a   = fifo_a[rd_ptr];
  assign commit_d   = fifo_d[rd_ptr];
  assign level_next = level + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  assign busy_next  = (level_next != '0) || commit;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_a[wr_ptr] <= cpu_a;
      fifo_d[wr_ptr] <= cpu_d;
    end
  end
`else
  // Depth only matters when the posted-write buffer is built in.
  logic [3:0] unused_depth;
  assign unused_depth = 4'(WBUF_DEPTH);

  assign push      = 1'b0;
  assign grant_rd  = !vid_req && cpu_live && !cpu_we;
  assign grant_wr  = !vid_req && cpu_live && cpu_we;
  assign commit    = grant_wr;
  assign commit_a  = cpu_a;
  assign commit_d  = cpu_d;
  assign busy_next = (state_next == ST_WR_WAIT);
`endif

  // Port mux: scanout, then CPU read, then write commit. mem_a/mem_d hold
  // their last value on idle cycles.
  always_comb begin
    mem_a_next = mem_a;
    mem_d_next = mem_d;
    if (vid_req) begin
      mem_a_next = vid_a;
    end else if (grant_rd) begin
      mem_a_next = cpu_a;
    end else if (commit) begin
      mem_a_next = commit_a;
      mem_d_next = commit_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (grant_rd) begin
          state_next = ST_RD_WAIT;
        end else if (grant_wr) begin
          state_next = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: state_next = ST_IDLE;
      ST_WR_WAIT: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_a     <= '0;
      mem_d     <= '0;
      mem_we    <= 1'b0;
      cpu_q     <= '0;
      cpu_ack   <= 1'b0;
      wbuf_busy <= 1'b0;
    end else begin
      mem_a     <= mem_a_next;
      mem_d     <= mem_d_next;
      mem_we    <= commit && !vid_req && !grant_rd;
      cpu_ack   <= (state == ST_RD_WAIT) || (state == ST_WR_WAIT) || push;
      wbuf_busy <= busy_next;
      // mem_q still belongs to the CPU address here, even if scanout has
      // just been granted the port for the next cycle.
      if (state == ST_RD_WAIT) cpu_q <= mem_q;
    end
  end

endmodule
